uart_tx_mmio: RTL
=================

// Module: uart_tx_mmio
// PURPOSE
//   Memory-mapped UART transmitter (8N1, LSB first) that drives the top-level tx_o pin.
//   Sits on the processor data bus next to RAM and the cycle-counter CSR.
//   Buffers CPU-written bytes in a small FIFO and serialises them at a fixed baud rate.
//   Exposes a status word for software polling.
// PARAMETERS
//   CLK_FREQ    100_000_000  clock frequency in Hz
//   BAUD_RATE   115_200      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 2)
//   FIFO_DEPTH  16           transmit FIFO entries; power of two, >= 2
//   BASE_ADDR   32'h8000_0010 byte address of the TXDATA register; STATUS is at BASE_ADDR+4
// PORTS
//   clk_i              in   1   single clock, all state on rising edge
//   rst_i              in   1   asynchronous, active-high reset
//   dbus_en_i          in   4   byte write enables from the processor
//   dbus_write_addr_i  in   32  write byte address
//   dbus_write_data_i  in   32  write data
//   dbus_read_addr_i   in   32  read byte address
//   dbus_read_data_o   out  32  combinational read data
//   tx_o               out  1   serial line, idle high
// BEHAVIOUR
// - Reset (async, immediate): tx_o=1, FIFO empty, FSM=IDLE, overflow=0, baud counter=0, bit index=0.
// - Push: dbus_en_i[0] && dbus_write_addr_i==BASE_ADDR -> dbus_write_data_i[7:0] is pushed.
//   - Other enables and other addresses are ignored.
//   - Accepted iff count<FIFO_DEPTH or a pop occurs on the same edge; otherwise dropped and overflow<=1.
// - Clear overflow: dbus_en_i[0] && addr==BASE_ADDR+4 && data[2]==1 -> overflow<=0.
//   - If a drop occurs on the same edge, set wins.
// - Read: dbus_read_data_o = {29'b0, overflow, busy, full} when dbus_read_addr_i==BASE_ADDR+4, else 0.
//   - full = (count==FIFO_DEPTH); busy = (FSM!=IDLE) || (count!=0).
// - FSM states and transitions:
//   - IDLE: tx_o=1. If FIFO non-empty: pop the head into the shift register, tx_o<=0, clear the baud counter, go to START.
//   - START: hold tx_o=0 for CLKS_PER_BIT cycles, then tx_o<=shift[0], go to DATA with bit index 0.
//   - DATA: each bit lasts CLKS_PER_BIT cycles, then shift right.
//     - After bit 7 completes: tx_o<=1, go to STOP.
//   - STOP: hold tx_o=1 for CLKS_PER_BIT cycles. At the end:
//     - FIFO non-empty: pop, tx_o<=0, go to START (no idle gap).
//     - FIFO empty: go to IDLE.
// - Latency: a byte pushed at edge N into an empty FIFO while IDLE pops at edge N+1, so tx_o falls after edge N+1.
//   - Frame = 10*CLKS_PER_BIT cycles.
// - Baud counter runs 0..CLKS_PER_BIT-1 and wraps. Bit index is 3 bits and wraps at 7 with no carry.
// - FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
// - A write to TXDATA during a frame never disturbs the frame in flight.
// TESTING (CLK_FREQ=8, BAUD_RATE=1 -> CLKS_PER_BIT=8; FIFO_DEPTH=4; BASE_ADDR=32'h8000_0010)
// 1. Write 0x55 once -> tx_o=0 for 8 clks, then 1,0,1,0,1,0,1,0 (8 clks each), then 1 for 8 clks.
//    STATUS bit1=1 for 80 clks after the pop, then STATUS=0.
// 2. Write 0xA5 and 0x3C on consecutive cycles -> two back-to-back frames, 160 clks, no high gap between the stop and the next start.
// 3. Write 6 bytes on cycles 0..5 while IDLE -> bytes 1..5 transmitted in order, byte 6 dropped.
//    STATUS=0x7 after cycle 5. Writing 0x4 to BASE+4 then yields bit2=0.
// 4. dbus_en_i=4'b0010 at BASE, then dbus_en_i=4'b0001 at BASE+8 -> no push, tx_o stays 1, STATUS=0.
// 5. Assert rst_i mid-DATA (bit 3) of a frame with 2 bytes queued -> tx_o=1 without a clock edge.
//    STATUS=0 and no further frames after release.
// 6. Drop while clearing overflow on the same edge -> overflow=1. Push on full with a simultaneous STOP->START pop -> accepted, overflow stays 0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a small FIFO, an FSM
// serialises them LSB first on tx_o, and a STATUS word exposes overflow/busy/full.
module uart_tx_mmio #(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          BAUD_RATE  = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0010
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  dbus_en_i,
  input  logic [31:0] dbus_write_addr_i,
  input  logic [31:0] dbus_write_data_i,
  input  logic [31:0] dbus_read_addr_i,
  output logic [31:0] dbus_read_data_o,
  output logic        tx_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE    = CNT_W'(1);
  localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             overflow;

  logic baud_end;
  logic fifo_empty;
  logic full;
  logic busy;
  logic pop;
  logic push_req;
  logic push;
  logic drop;
  logic clr_ovf;
  logic unused_bits;

  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign fifo_empty = (count == '0);
  assign full       = (count == DEPTH_C);
  assign busy       = (state != IDLE) || !fifo_empty;

  // A pop frees a slot on the same edge, so a write to a full FIFO still lands then.
  assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
  assign push_req = dbus_en_i[0] && (dbus_write_addr_i == BASE_ADDR);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign clr_ovf  = dbus_en_i[0] && (dbus_write_addr_i == STATUS_ADDR) && dbus_write_data_i[2];

  assign dbus_read_data_o = (dbus_read_addr_i == STATUS_ADDR) ?
                            {29'b0, overflow, busy, full} : 32'b0;

  assign unused_bits = ^{dbus_en_i[3:1], dbus_write_data_i[31:8]};

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= dbus_write_data_i[7:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A drop on the same edge as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Shift register is pure data: loaded on pop, shifted after each data bit.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      shift <= fifo_mem[rd_ptr];
    end else if ((state == DATA) && baud_end && (bit_idx != 3'd7)) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      tx_o     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            tx_o     <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx_o     <= shift[0];
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              tx_o    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              tx_o  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
